// File: rtl/chimp_board_engine.sv
// Chimp-test memory game board engine.
// Clears a GRIDxGRID board, scatters numbers 1..L onto random free cells,
// then judges user clicks that must hit the numbers in ascending order.
// Numbers are visible until the first correct click and are revealed
// again once the round is won or lost.
module chimp_board_engine #(
  parameter  int GRID    = 8,
  parameter  int MAX_NUM = 31,
  localparam int CW      = $clog2(GRID),
  localparam int NW      = $clog2(MAX_NUM + 1)
) (
  input  logic            clk,
  input  logic            iResetn,
  input  logic            iStart,
  input  logic [NW-1:0]   iLevel,
  input  logic [2*CW-1:0] iRandNum,
  input  logic            iClickValid,
  input  logic [CW-1:0]   iBoxX,
  input  logic [CW-1:0]   iBoxY,
  input  logic [CW-1:0]   iRdX,
  input  logic [CW-1:0]   iRdY,
  output logic [NW+1:0]   oRdCell,
  output logic            oClickDone,
  output logic            oCorrect,
  output logic            oWin,
  output logic            oLose,
  output logic            oBusy,
  output logic [NW-1:0]   oNextNum
);

  localparam int CELLS = GRID * GRID;
  localparam int AW    = $clog2(CELLS);
  localparam int LAST  = CELLS - 1;
  localparam int LMAX  = (MAX_NUM < CELLS) ? MAX_NUM : CELLS;

  localparam logic [CW:0]   GRID_C = GRID[CW:0];
  localparam logic [AW-1:0] GRID_A = GRID[AW-1:0];
  localparam logic [AW-1:0] LAST_A = LAST[AW-1:0];
  localparam logic [NW-1:0] LMAX_N = LMAX[NW-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHOW,
    S_PLAY,
    S_WIN,
    S_LOSE
  } state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] level_q, level_d;
  logic [NW-1:0] count_q, count_d;
  logic [NW-1:0] next_q,  next_d;
  logic [AW-1:0] clr_q,   clr_d;

  // Each cell is {active, number}.
  logic [NW:0]   board [CELLS];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NW:0]   wr_data;
  logic          done_d;
  logic          correct_d;

  logic          shown;
  logic [CW-1:0] rand_x, rand_y;
  logic          rand_in;
  logic [AW-1:0] rand_addr;
  logic [NW:0]   rand_cell;
  logic          box_in;
  logic [AW-1:0] box_addr;
  logic [NW:0]   box_cell;
  logic          box_hit;
  logic          rd_in;
  logic [NW:0]   rd_cell;
  logic [NW-1:0] cnt_inc;

  function automatic logic in_grid(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return ({1'b0, x} < GRID_C) && ({1'b0, y} < GRID_C);
  endfunction

  // Raster order: x runs fastest.
  function automatic logic [AW-1:0] cell_addr(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return AW'(y) * GRID_A + AW'(x);
  endfunction

  function automatic logic [NW-1:0] clamp_level(input logic [NW-1:0] lv);
    if (lv == '0)         return NW'(1);
    else if (lv > LMAX_N) return LMAX_N;
    else                  return lv;
  endfunction

  assign rand_x    = iRandNum[CW-1:0];
  assign rand_y    = iRandNum[2*CW-1:CW];
  assign rand_in   = in_grid(rand_x, rand_y);
  assign rand_addr = cell_addr(rand_x, rand_y);
  assign rand_cell = board[rand_addr];
  assign cnt_inc   = count_q + NW'(1);

  assign box_in    = in_grid(iBoxX, iBoxY);
  assign box_addr  = cell_addr(iBoxX, iBoxY);
  assign box_cell  = board[box_addr];
  assign box_hit   = box_in && box_cell[NW] && (box_cell[NW-1:0] == next_q);

  assign rd_in     = in_grid(iRdX, iRdY);
  assign rd_cell   = board[cell_addr(iRdX, iRdY)];

  // Numbers are visible while loading/memorising and revealed at round end.
  assign shown     = (state_q == S_LOAD) || (state_q == S_SHOW) ||
                     (state_q == S_WIN)  || (state_q == S_LOSE);

  assign oBusy     = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign oWin      = (state_q == S_WIN);
  assign oLose     = (state_q == S_LOSE);
  assign oNextNum  = next_q;

  // Next-state, board write port and click judgement.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    level_d   = level_q;
    count_d   = count_q;
    next_d    = next_q;
    clr_d     = clr_q;
    wr_en     = 1'b0;
    wr_addr   = clr_q;
    wr_data   = '0;
    done_d    = 1'b0;
    correct_d = 1'b0;

    if (iStart) begin
      // A start always wins, including over a click in the same cycle.
      state_d = S_CLEAR;
      level_d = clamp_level(iLevel);
      count_d = '0;
      next_d  = NW'(1);
      clr_d   = '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          wr_en = 1'b1;
          clr_d = clr_q + AW'(1);
          if (clr_q == LAST_A) state_d = S_LOAD;
        end
        S_LOAD: begin
          // Out-of-range or occupied samples are silently dropped and retried.
          if (rand_in && !rand_cell[NW]) begin
            wr_en   = 1'b1;
            wr_addr = rand_addr;
            wr_data = {1'b1, cnt_inc};
            count_d = cnt_inc;
            if (cnt_inc == level_q) state_d = S_SHOW;
          end
        end
        S_SHOW, S_PLAY: begin
          if (iClickValid) begin
            done_d = 1'b1;
            if (box_hit) begin
              correct_d = 1'b1;
              wr_en     = 1'b1;
              wr_addr   = box_addr;
              wr_data   = {1'b0, box_cell[NW-1:0]};
              next_d    = next_q + NW'(1);
              state_d   = (box_cell[NW-1:0] == level_q) ? S_WIN : S_PLAY;
            end else begin
              state_d   = S_LOSE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Round bookkeeping and registered click result.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_q    <= S_IDLE;
      level_q    <= NW'(1);
      count_q    <= '0;
      next_q     <= NW'(1);
      clr_q      <= '0;
      oClickDone <= 1'b0;
      oCorrect   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      level_q    <= level_d;
      count_q    <= count_d;
      next_q     <= next_d;
      clr_q      <= clr_d;
      oClickDone <= done_d;
      oCorrect   <= correct_d;
    end
  end

  // Board storage with its single write port.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      // NOTE: reset must wipe the whole board, so the storage is flops rather than a RAM.
      for (int i = 0; i < CELLS; i++) board[i] <= '0;
    end else if (wr_en) begin
      board[wr_addr] <= wr_data;
    end
  end

  // Registered display read; the shown bit is masked by the cell's active bit.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      oRdCell <= '0;
    end else if (rd_in) begin
      oRdCell <= {rd_cell[NW], rd_cell[NW] & shown, rd_cell[NW-1:0]};
    end else begin
      oRdCell <= '0;
    end
  end

endmodule

// File: tb/tb_chimp_board_engine.sv
// Self-checking bench for chimp_board_engine. Two instances share stimulus:
// GRID=8 for the main flow and GRID=6 so out-of-range coordinates exist.
module tb_chimp_board_engine;

  logic       clk;
  logic       iResetn;
  logic       iStart;
  logic [4:0] iLevel;
  logic [5:0] iRandNum;
  logic       iClickValid;
  logic [2:0] iBoxX, iBoxY, iRdX, iRdY;

  logic [6:0] a_rd, b_rd;
  logic       a_done, a_corr, a_win, a_lose, a_busy;
  logic       b_done, b_corr, b_win, b_lose, b_busy;
  logic [4:0] a_next, b_next;

  int errors;
  int checks;

  // Stimulus samples for LOAD and the bench's own board model.
  logic [5:0] seq[$];
  logic       exp_act[64];
  logic [4:0] exp_num[64];
  logic [5:0] pos_of[32];

  // Scoreboard queues.
  logic [6:0] rd_exp_q[$];
  logic       corr_exp_q[$];

  chimp_board_engine #(.GRID(8), .MAX_NUM(31)) u_dut8 (
    .clk(clk), .iResetn(iResetn), .iStart(iStart), .iLevel(iLevel),
    .iRandNum(iRandNum), .iClickValid(iClickValid), .iBoxX(iBoxX), .iBoxY(iBoxY),
    .iRdX(iRdX), .iRdY(iRdY), .oRdCell(a_rd), .oClickDone(a_done),
    .oCorrect(a_corr), .oWin(a_win), .oLose(a_lose), .oBusy(a_busy),
    .oNextNum(a_next)
  );

  chimp_board_engine #(.GRID(6), .MAX_NUM(31)) u_dut6 (
    .clk(clk), .iResetn(iResetn), .iStart(iStart), .iLevel(iLevel),
    .iRandNum(iRandNum), .iClickValid(iClickValid), .iBoxX(iBoxX), .iBoxY(iBoxY),
    .iRdX(iRdX), .iRdY(iRdY), .oRdCell(b_rd), .oClickDone(b_done),
    .oCorrect(b_corr), .oWin(b_win), .oLose(b_lose), .oBusy(b_busy),
    .oNextNum(b_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] xy(input int x, input int y);
    return {y[2:0], x[2:0]};
  endfunction

  function automatic logic [6:0] exp_rd(input logic [5:0] s, input logic shown);
    return {exp_act[s], exp_act[s] & shown, exp_num[s]};
  endfunction

  // Expected placement of numbers given the sample stream.
  task automatic model_load(input int grid, input int lvl, output int consumed);
    int lim, lv, cnt;
    logic [5:0] s;
    for (int i = 0; i < 64; i++) begin
      exp_act[i] = 1'b0;
      exp_num[i] = '0;
    end
    lim = (31 < grid * grid) ? 31 : grid * grid;
    lv  = (lvl == 0) ? 1 : ((lvl > lim) ? lim : lvl);
    cnt = 0;
    consumed = -1;
    for (int i = 0; i < seq.size(); i++) begin
      s = seq[i];
      if (int'(s[2:0]) < grid && int'(s[5:3]) < grid && !exp_act[s]) begin
        exp_act[s] = 1'b1;
        cnt++;
        exp_num[s] = 5'(cnt);
        pos_of[cnt] = s;
        if (cnt == lv) begin
          consumed = i + 1;
          break;
        end
      end
    end
  endtask

  // Pulse iStart (optionally with a simultaneous click) and feed samples until idle of busy.
  task automatic start_round(input int sel, input int lvl, input logic with_click,
                             input logic [5:0] click_s, output int busy_cnt,
                             output int exp_busy, output logic first_done,
                             output logic timed_out);
    int cells, grid, consumed, idx;
    grid  = (sel != 0) ? 6 : 8;
    cells = grid * grid;
    model_load(grid, lvl, consumed);
    exp_busy = cells + consumed;
    iStart   = 1'b1;
    iLevel   = 5'(lvl);
    iRandNum = seq[0];
    if (with_click) begin
      iClickValid = 1'b1;
      iBoxX = click_s[2:0];
      iBoxY = click_s[5:3];
    end
    @(negedge clk);
    iStart      = 1'b0;
    iClickValid = 1'b0;
    first_done  = (sel != 0) ? b_done : a_done;
    busy_cnt    = 0;
    timed_out   = 1'b1;
    for (int j = 1; j < 400; j++) begin
      if (!((sel != 0) ? b_busy : a_busy)) begin
        timed_out = 1'b0;
        break;
      end
      busy_cnt++;
      idx = j - cells - 1;
      if (idx < 0) idx = 0;
      if (idx >= seq.size()) idx = seq.size() - 1;
      iRandNum = seq[idx];
      @(negedge clk);
    end
  endtask

  task automatic do_read(input int sel, input logic [5:0] s, output logic [6:0] got);
    iRdX = s[2:0];
    iRdY = s[5:3];
    @(negedge clk);
    got = (sel != 0) ? b_rd : a_rd;
  endtask

  task automatic do_click(input int sel, input logic [5:0] s, output logic done,
                          output logic corr, output logic done2);
    iClickValid = 1'b1;
    iBoxX = s[2:0];
    iBoxY = s[5:3];
    @(negedge clk);
    iClickValid = 1'b0;
    done = (sel != 0) ? b_done : a_done;
    corr = (sel != 0) ? b_corr : a_corr;
    @(negedge clk);
    done2 = (sel != 0) ? b_done : a_done;
  endtask

  task automatic test_reset();
    iResetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if ({a_win, a_lose} !== 2'b00) begin errors++; $display("FAIL reset_win_lose got=%b exp=00", {a_win, a_lose}); end
    checks++; if ({a_done, a_corr} !== 2'b00) begin errors++; $display("FAIL reset_click got=%b exp=00", {a_done, a_corr}); end
    checks++; if (a_next !== 5'd1) begin errors++; $display("FAIL reset_next got=%0d exp=1", a_next); end
    checks++; if (a_rd !== 7'd0) begin errors++; $display("FAIL reset_rd got=%h exp=0", a_rd); end
    checks++; if (b_next !== 5'd1) begin errors++; $display("FAIL reset_next6 got=%0d exp=1", b_next); end
    iResetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", a_busy); end
  endtask

  task automatic test_load_show();
    int bc, eb;
    logic fd, to;
    logic [6:0] got, e;
    seq = '{xy(1, 2), xy(5, 0), xy(7, 7), xy(0, 3)};
    start_round(0, 4, 1'b0, 6'd0, bc, eb, fd, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL load_timeout got=%b exp=0", to); end
    checks++; if (bc !== eb) begin errors++; $display("FAIL busy_cycles got=%0d exp=%0d", bc, eb); end
    checks++; if (a_next !== 5'd1) begin errors++; $display("FAIL show_next got=%0d exp=1", a_next); end
    for (int n = 1; n <= 4; n++) begin
      rd_exp_q.push_back(exp_rd(pos_of[n], 1'b1));
      do_read(0, pos_of[n], got);
      e = rd_exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL show_read n=%0d got=%h exp=%h", n, got, e); end
    end
    rd_exp_q.push_back(7'd0);
    do_read(0, xy(3, 3), got);
    e = rd_exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL empty_read got=%h exp=%h", got, e); end
  endtask

  task automatic test_play_win();
    logic done, corr, done2, ec;
    logic [6:0] got, e;
    for (int n = 1; n <= 4; n++) begin
      corr_exp_q.push_back(1'b1);
      do_click(0, pos_of[n], done, corr, done2);
      ec = corr_exp_q.pop_front();
      exp_act[pos_of[n]] = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL win_done n=%0d got=%b exp=1", n, done); end
      checks++; if (corr !== ec) begin errors++; $display("FAIL win_correct n=%0d got=%b exp=%b", n, corr, ec); end
      checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL done_pulse n=%0d got=%b exp=0", n, done2); end
      if (n == 1) begin
        checks++; if (a_next !== 5'd2) begin errors++; $display("FAIL next_after1 got=%0d exp=2", a_next); end
        rd_exp_q.push_back(exp_rd(pos_of[2], 1'b0));
        do_read(0, pos_of[2], got);
        e = rd_exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL play_hidden got=%h exp=%h", got, e); end
      end
    end
    checks++; if ({a_win, a_lose} !== 2'b10) begin errors++; $display("FAIL win_level got=%b exp=10", {a_win, a_lose}); end
    for (int n = 1; n <= 4; n++) begin
      rd_exp_q.push_back(exp_rd(pos_of[n], 1'b1));
      do_read(0, pos_of[n], got);
      e = rd_exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL win_read n=%0d got=%h exp=%h", n, got, e); end
    end
    do_click(0, pos_of[1], done, corr, done2);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL click_in_win got=%b exp=0", done); end
    checks++; if (a_win !== 1'b1) begin errors++; $display("FAIL win_hold got=%b exp=1", a_win); end
  endtask

  task automatic test_lose();
    int bc, eb;
    logic fd, to, done, corr, done2, ec;
    logic [6:0] got, e;
    seq = '{xy(2, 2), xy(3, 1), xy(6, 5), xy(4, 6)};
    start_round(0, 4, 1'b0, 6'd0, bc, eb, fd, to);
    checks++; if (bc !== eb || to !== 1'b0) begin errors++; $display("FAIL lose_busy got=%0d exp=%0d", bc, eb); end
    checks++; if (a_win !== 1'b0) begin errors++; $display("FAIL win_cleared got=%b exp=0", a_win); end
    corr_exp_q.push_back(1'b1);
    do_click(0, pos_of[1], done, corr, done2);
    ec = corr_exp_q.pop_front();
    exp_act[pos_of[1]] = 1'b0;
    checks++; if (corr !== ec) begin errors++; $display("FAIL lose_first got=%b exp=%b", corr, ec); end
    corr_exp_q.push_back(1'b0);
    do_click(0, pos_of[3], done, corr, done2);
    ec = corr_exp_q.pop_front();
    checks++; if ({done, corr} !== {1'b1, ec}) begin errors++; $display("FAIL wrong_click got=%b exp=%b", {done, corr}, {1'b1, ec}); end
    checks++; if ({a_win, a_lose} !== 2'b01) begin errors++; $display("FAIL lose_level got=%b exp=01", {a_win, a_lose}); end
    checks++; if (a_next !== 5'd2) begin errors++; $display("FAIL lose_next got=%0d exp=2", a_next); end
    for (int n = 1; n <= 4; n++) begin
      rd_exp_q.push_back(exp_rd(pos_of[n], 1'b1));
      do_read(0, pos_of[n], got);
      e = rd_exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL lose_read n=%0d got=%h exp=%h", n, got, e); end
    end
  endtask

  task automatic test_start_collision_level0();
    int bc, eb;
    logic fd, to, done, corr, done2;
    logic [6:0] got, e;
    seq = '{xy(0, 0), xy(1, 0)};
    start_round(0, 2, 1'b0, 6'd0, bc, eb, fd, to);
    seq = '{xy(4, 4), xy(4, 4)};
    start_round(0, 0, 1'b1, xy(0, 0), bc, eb, fd, to);
    checks++; if (fd !== 1'b0) begin errors++; $display("FAIL collide_done got=%b exp=0", fd); end
    checks++; if (bc !== eb || to !== 1'b0) begin errors++; $display("FAIL lvl0_busy got=%0d exp=%0d", bc, eb); end
    rd_exp_q.push_back(exp_rd(xy(4, 4), 1'b1));
    do_read(0, xy(4, 4), got);
    e = rd_exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL lvl0_read got=%h exp=%h", got, e); end
    rd_exp_q.push_back(exp_rd(xy(0, 0), 1'b1));
    do_read(0, xy(0, 0), got);
    e = rd_exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL lvl0_cleared got=%h exp=%h", got, e); end
    do_click(0, xy(4, 4), done, corr, done2);
    checks++; if ({done, corr, a_win} !== 3'b111) begin errors++; $display("FAIL lvl0_win got=%b exp=111", {done, corr, a_win}); end
  endtask

  task automatic test_reset_in_load();
    logic done, corr, done2;
    logic [6:0] got, e;
    iStart   = 1'b1;
    iLevel   = 5'd3;
    iRandNum = xy(2, 3);
    @(negedge clk);
    iStart = 1'b0;
    repeat (65) @(negedge clk);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL in_load_busy got=%b exp=1", a_busy); end
    iResetn = 1'b0;
    #1;
    checks++; if ({a_busy, a_win, a_lose} !== 3'b000) begin errors++; $display("FAIL async_reset got=%b exp=000", {a_busy, a_win, a_lose}); end
    checks++; if (a_next !== 5'd1) begin errors++; $display("FAIL async_next got=%0d exp=1", a_next); end
    @(negedge clk);
    iResetn = 1'b1;
    @(negedge clk);
    checks++; if ({a_done, a_corr} !== 2'b00) begin errors++; $display("FAIL release_pulse got=%b exp=00", {a_done, a_corr}); end
    for (int k = 0; k < 2; k++) begin
      rd_exp_q.push_back(7'd0);
      do_read(0, (k == 0) ? xy(2, 3) : xy(5, 5), got);
      e = rd_exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL reset_board k=%0d got=%h exp=%h", k, got, e); end
    end
    do_click(0, xy(2, 3), done, corr, done2);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL click_in_idle got=%b exp=0", done); end
  endtask

  task automatic test_grid6_reject();
    int bc, eb;
    logic fd, to, done, corr, done2;
    logic [6:0] got, e;
    seq = '{xy(1, 1), xy(1, 1), xy(6, 2), xy(2, 4), xy(0, 0)};
    start_round(1, 2, 1'b0, 6'd0, bc, eb, fd, to);
    checks++; if (bc !== 40 || to !== 1'b0) begin errors++; $display("FAIL g6_busy got=%0d exp=40", bc); end
    checks++; if (eb !== 40) begin errors++; $display("FAIL g6_model got=%0d exp=40", eb); end
    rd_exp_q.push_back(7'b1100001);
    do_read(1, xy(1, 1), got);
    e = rd_exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL g6_read1 got=%h exp=%h", got, e); end
    rd_exp_q.push_back(7'b1100010);
    do_read(1, xy(2, 4), got);
    e = rd_exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL g6_read2 got=%h exp=%h", got, e); end
    rd_exp_q.push_back(7'd0);
    do_read(1, xy(6, 2), got);
    e = rd_exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL g6_oob_read got=%h exp=%h", got, e); end
    rd_exp_q.push_back(7'd0);
    do_read(1, xy(0, 0), got);
    e = rd_exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL g6_unused got=%h exp=%h", got, e); end
    do_click(1, xy(7, 0), done, corr, done2);
    checks++; if ({done, corr, b_lose} !== 3'b101) begin errors++; $display("FAIL g6_oob_click got=%b exp=101", {done, corr, b_lose}); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    iResetn     = 1'b0;
    iStart      = 1'b0;
    iLevel      = '0;
    iRandNum    = '0;
    iClickValid = 1'b0;
    iBoxX       = '0;
    iBoxY       = '0;
    iRdX        = '0;
    iRdY        = '0;
    test_reset();
    test_load_show();
    test_play_win();
    test_lose();
    test_start_collision_level0();
    test_reset_in_load();
    test_grid6_reject();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
